// File: rtl/rx_frame_buffer_if.sv
// Bundle of the receive-side byte stream, the buffered output stream and the
// status counters of rx_frame_buffer.
//
// Handshake rules:
//   in_*  : no backpressure. A byte is taken on every rising clk edge where
//           in_vld is high. in_sop and in_eop only mean something while in_vld
//           is high.
//   out_* : a byte transfers on a rising edge where out_vld and out_rdy are
//           both high. Once out_vld is high it stays high, and out_data,
//           out_sop and out_eop stay unchanged, until that transfer happens.
//           out_vld never waits on out_rdy.
interface rx_frame_buffer_if #(
   parameter int AW = 11
);
   logic          in_vld;
   logic          in_sop;
   logic          in_eop;
   logic [7:0]    in_data;

   logic          out_vld;
   logic          out_rdy;
   logic [7:0]    out_data;
   logic          out_sop;
   logic          out_eop;

   logic [AW:0]   frames_pending;
   logic [15:0]   drop_cnt;

   // Write FSM state: 0 idle, 1 writing a frame, 2 dropping a frame
   logic [1:0]    dbg_wr_state;

   // Environment side: drives the received stream and the consumer ready
   modport master (
      output in_vld, in_sop, in_eop, in_data, out_rdy,
      input  out_vld, out_data, out_sop, out_eop,
      input  frames_pending, drop_cnt, dbg_wr_state
   );

   // Buffer side
   modport slave (
      input  in_vld, in_sop, in_eop, in_data, out_rdy,
      output out_vld, out_data, out_sop, out_eop,
      output frames_pending, drop_cnt, dbg_wr_state
   );
endinterface

// File: rtl/rx_frame_buffer.sv
// Receive frame buffer. It stores whole Ethernet frames from a receive stream
// that cannot be stalled, and only releases a frame to the consumer after its
// last byte has been stored. A frame that is cut short by a new sop, or that
// does not fit, is discarded and counted in drop_cnt.
//
// Storage is a DEPTH x 9 RAM holding {eop, data}. Three pointers, each AW+1
// bits wide, wrap modulo 2*DEPTH:
//   wr_ptr     : next write slot, which may point into an uncommitted frame
//   commit_ptr : end of the last complete frame; the reader never passes it
//   rd_ptr     : next slot to fetch from the RAM
// The buffer is full when wr_ptr - rd_ptr == DEPTH. The extra pointer bit
// tells full apart from empty after the pointers wrap.
//
// Read path: synchronous RAM read into ram_q (stage 1), then the output
// register. A stalled output register holds stage 1 in place, so stage 1 acts
// as the skid entry and no extra buffer is needed. With out_rdy held high,
// one byte is fetched and one byte is delivered on every cycle.
module rx_frame_buffer #(
   parameter int DEPTH = 2048,
   parameter int AW    = 11
) (
   input  logic             clk,
   input  logic             rst,
   rx_frame_buffer_if.slave bus
);

   localparam logic [AW:0] PTR_DEPTH = DEPTH[AW:0];
   localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_DROP = 2'd2
   } wr_state_e;

   // Write side state
   wr_state_e     state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   commit_ptr_q, commit_ptr_d;
   logic [AW:0]   pend_q, pend_d;
   logic [15:0]   drop_q, drop_d;

   // Read side state
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          s1_vld_q, s1_vld_d;
   logic          out_vld_q, out_vld_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          out_sop_q, out_sop_d;
   logic          out_eop_q, out_eop_d;
   logic          after_eop_q, after_eop_d;

   // Storage
   logic [8:0]    mem [DEPTH];
   logic [8:0]    ram_q;

   // Combinational helpers
   logic [AW:0]   wr_base;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic          commit;
   logic [1:0]    drop_inc;
   logic [16:0]   drop_sum;
   logic          rd_en;
   logic          s1_move;
   logic          eop_pop;

   // Write FSM next state. A sop restarts the frame at commit_ptr from any
   // state, so a partial frame is discarded just by rewinding the pointer.
   // A sop that arrives while a frame is being written counts one drop. A byte
   // that does not fit counts one more drop.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      mem_we       = 1'b0;
      mem_waddr    = wr_ptr_q[AW-1:0];
      commit       = 1'b0;
      drop_inc     = 2'd0;
      wr_base      = bus.in_sop ? commit_ptr_q : wr_ptr_q;

      if (bus.in_vld && (bus.in_sop || state_q == S_WR)) begin
         if (bus.in_sop && state_q == S_WR) begin
            drop_inc = 2'd1;
         end
         if ((wr_base - rd_ptr_q) == PTR_DEPTH) begin
            // No room: give up the frame and leave committed data untouched
            wr_ptr_d = commit_ptr_q;
            drop_inc = drop_inc + 2'd1;
            state_d  = bus.in_eop ? S_IDLE : S_DROP;
         end else begin
            mem_we    = 1'b1;
            mem_waddr = wr_base[AW-1:0];
            wr_ptr_d  = wr_base + PTR_ONE;
            if (bus.in_eop) begin
               commit_ptr_d = wr_base + PTR_ONE;
               commit       = 1'b1;
               state_d      = S_IDLE;
            end else begin
               state_d = S_WR;
            end
         end
      end
   end

   // Drop counter saturates at 0xFFFF. frames_pending goes up on a commit and
   // down when the consumer accepts an eop byte. If both happen in the same
   // cycle, the count stays the same.
   always_comb begin
      drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      eop_pop  = out_vld_q && bus.out_rdy && out_eop_q;
      pend_d   = pend_q;
      if (commit && !eop_pop) begin
         pend_d = pend_q + PTR_ONE;
      end else if (!commit && eop_pop) begin
         pend_d = pend_q - PTR_ONE;
      end
   end

   // Read pipeline: fetch only committed bytes, and move stage 1 forward when
   // the output register is empty or is being accepted. A new fetch is issued
   // only when stage 1 will be free, so stage 1 holds its byte during a stall.
   always_comb begin
      s1_move     = s1_vld_q && (!out_vld_q || bus.out_rdy);
      rd_en       = (rd_ptr_q != commit_ptr_q) && (!s1_vld_q || s1_move);
      rd_ptr_d    = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      s1_vld_d    = rd_en ? 1'b1 : (s1_move ? 1'b0 : s1_vld_q);

      out_vld_d   = out_vld_q;
      out_data_d  = out_data_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      after_eop_d = after_eop_q;
      if (s1_move) begin
         out_vld_d   = 1'b1;
         out_data_d  = ram_q[7:0];
         out_eop_d   = ram_q[8];
         out_sop_d   = after_eop_q;
         after_eop_d = ram_q[8];
      end else if (out_vld_q && bus.out_rdy) begin
         out_vld_d = 1'b0;
      end
   end

   // State registers, including the write FSM state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         pend_q       <= '0;
         drop_q       <= '0;
         s1_vld_q     <= 1'b0;
         out_vld_q    <= 1'b0;
         out_data_q   <= '0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         after_eop_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pend_q       <= pend_d;
         drop_q       <= drop_d;
         s1_vld_q     <= s1_vld_d;
         out_vld_q    <= out_vld_d;
         out_data_q   <= out_data_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         after_eop_q  <= after_eop_d;
      end
   end

   // Frame RAM. It is not reset because the pointers decide what is valid.
   // The reader never addresses the slot being written: the reader stays below
   // commit_ptr, and the writer stays at or above it.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[mem_waddr] <= {bus.in_eop, bus.in_data};
      end
      if (rd_en) begin
         ram_q <= mem[rd_ptr_q[AW-1:0]];
      end
   end

   assign bus.out_vld        = out_vld_q;
   assign bus.out_data       = out_data_q;
   assign bus.out_sop        = out_sop_q;
   assign bus.out_eop        = out_eop_q;
   assign bus.frames_pending = pend_q;
   assign bus.drop_cnt       = drop_q;
   assign bus.dbg_wr_state   = state_q;

endmodule
